// File: rtl/mic_serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mic_serial_pkg
//  Description : Shared FSM state encoding and parameter defaults for the
//                mic array serial bank.
//  Revision    : 1.0 - initial release
// ============================================================================
package mic_serial_pkg;

    localparam int c_N_CH_DEFAULT    = 16;
    localparam int c_WORD_W_DEFAULT  = 32;
    localparam int c_CLK_DIV_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mic_serial_clkgen.sv
`default_nettype none
// ============================================================================
//  Module      : mic_serial_clkgen
//  Description : Divided serial clock with single-cycle strobes that fire in
//                the cycle before the serial clock rises or falls.
//  Revision    : 1.0 - initial release
// ============================================================================
module mic_serial_clkgen
    import mic_serial_pkg::*;
#(
    parameter int CLK_DIV = c_CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise,
    output logic o_fall
);

    localparam int                 c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

    logic [c_DIV_W-1:0] r_div;
    logic               r_sclk;
    logic               w_tick;

    assign w_tick = i_en && (r_div == c_DIV_LAST);
    assign o_sclk = r_sclk;
    assign o_rise = w_tick && !r_sclk;
    assign o_fall = w_tick &&  r_sclk;

    // Disabling clears the phase so every transaction starts from the same point.
    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_div  <= '0;
            r_sclk <= 1'b0;
        end else if (w_tick) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_div  <= r_div + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mic_serial_bank.sv
`default_nettype none
// ============================================================================
//  Module      : mic_serial_bank
//  Description : N-channel full-duplex serial shifter sharing one serial
//                clock, with valid/ready command and response handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module mic_serial_bank
    import mic_serial_pkg::*;
#(
    parameter int N_CH    = c_N_CH_DEFAULT,
    parameter int WORD_W  = c_WORD_W_DEFAULT,
    parameter int CLK_DIV = c_CLK_DIV_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [N_CH*WORD_W-1:0] cmd_data,
    input  logic [N_CH-1:0]        cmd_mask,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [N_CH*WORD_W-1:0] rsp_data,
    output logic                   busy_out,
    output logic                   serial_clk_out,
    output logic [N_CH-1:0]        serial_data_out,
    input  logic [N_CH-1:0]        serial_data_in
);

    localparam int                 c_CNT_W    = $clog2(WORD_W + 1);
    localparam logic [c_CNT_W-1:0] c_WORD_CNT = c_CNT_W'(WORD_W);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [N_CH*WORD_W-1:0]  r_tx_sreg;
    logic [N_CH*WORD_W-1:0]  r_rx_sreg;
    logic [N_CH*WORD_W-1:0]  r_rsp_data;
    logic [N_CH-1:0]         r_mask;
    logic [c_CNT_W-1:0]      r_bit_cnt;

    logic [N_CH*WORD_W-1:0]  w_cmd_mask_bits;
    logic [N_CH*WORD_W-1:0]  w_rx_mask_bits;
    logic [N_CH*WORD_W-1:0]  w_tx_shifted;
    logic [N_CH*WORD_W-1:0]  w_rx_shifted;
    logic                    w_shift;
    logic                    w_rise;
    logic                    w_fall;
    logic                    w_last_fall;
    logic                    w_accept;

    assign w_shift     = (r_state == SHIFT);
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_last_fall = w_fall && (r_bit_cnt == c_WORD_CNT);
    assign rsp_data    = r_rsp_data;

    mic_serial_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk    (clk),
        .rst    (reset),
        .i_en   (w_shift),
        .o_sclk (serial_clk_out),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign w_cmd_mask_bits[c*WORD_W +: WORD_W] = {WORD_W{cmd_mask[c]}};
        assign w_rx_mask_bits[c*WORD_W +: WORD_W]  = {WORD_W{r_mask[c]}};
        assign w_tx_shifted[c*WORD_W +: WORD_W]    = {r_tx_sreg[c*WORD_W +: WORD_W-1], 1'b0};
        assign w_rx_shifted[c*WORD_W +: WORD_W]    = {r_rx_sreg[c*WORD_W +: WORD_W-1], serial_data_in[c]};
        // Disabled channels were loaded with zero, so their MSB stays low.
        assign serial_data_out[c] = w_shift && r_tx_sreg[c*WORD_W + WORD_W - 1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_tx_sreg  <= '0;
            r_rx_sreg  <= '0;
            r_rsp_data <= '0;
            r_mask     <= '0;
            r_bit_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_tx_sreg <= cmd_data & w_cmd_mask_bits;
                r_mask    <= cmd_mask;
                r_rx_sreg <= '0;
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                if (w_rise) begin
                    r_rx_sreg <= w_rx_shifted;
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
                if (w_fall && !w_last_fall) begin
                    r_tx_sreg <= w_tx_shifted;
                end
                if (w_last_fall) begin
                    r_rsp_data <= r_rx_sreg & w_rx_mask_bits;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        busy_out    = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy_out = 1'b1;
                if (w_last_fall) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                busy_out  = 1'b1;
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/mic_serial_bank.md
MIC_SERIAL_BANK -- requirements
Module: mic_serial_bank

Interface
REQ-001 Parameter N_CH, default 16: number of mic array channels sharing one serial clock.
REQ-002 Parameter WORD_W, default 32: bits per serial transaction per channel; SHALL be >= 2.
REQ-003 Parameter CLK_DIV, default 4: clk cycles per serial clock half-period; SHALL be >= 1.
REQ-004 clk  in  1  system clock; the only clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-008 cmd_data  in  N_CH*WORD_W  per-channel TX word; channel c occupies bits [c*WORD_W +: WORD_W].
REQ-009 cmd_mask  in  N_CH  per-channel enable; 1 = channel takes part.
REQ-010 rsp_valid  out  1  response available.
REQ-011 rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
REQ-012 rsp_data  out  N_CH*WORD_W  per-channel RX word, same packing as cmd_data.
REQ-013 busy_out  out  1  transaction in progress or response pending.
REQ-014 serial_clk_out  out  1  shared serial clock; idles low.
REQ-015 serial_data_out  out  N_CH  per-channel serial TX.
REQ-016 serial_data_in  in  N_CH  per-channel serial RX.

Function
REQ-017 FSM states: IDLE, SHIFT, DONE; cmd_ready SHALL be 1 only in IDLE; busy_out SHALL be 1 in SHIFT and DONE.
REQ-018 IDLE: on cmd_valid && cmd_ready, latch cmd_data and cmd_mask, clear the divider, enter SHIFT; in the cycle after acceptance, drive the MSB of each enabled channel on serial_data_out.
REQ-019 SHIFT: serial_clk_out SHALL toggle every CLK_DIV clk cycles. The first rising edge comes CLK_DIV cycles after acceptance.
REQ-020 On each rising edge, sample serial_data_in into the channel RX shift register, MSB first.
REQ-021 On each falling edge except the last, shift the next TX bit onto serial_data_out.
REQ-022 Exactly WORD_W rising edges per transaction.
REQ-023 The last falling edge occurs 2*CLK_DIV*WORD_W cycles after acceptance; the FSM SHALL then enter DONE, with rsp_valid = 1 in the following cycle.
REQ-024 Disabled channels (mask bit 0): serial_data_out held 0 for the whole transaction; corresponding rsp_data word = 0.
REQ-025 DONE: rsp_valid and rsp_data SHALL remain stable until rsp_ready. On rsp_valid && rsp_ready, return to IDLE, with rsp_valid = 0 in the next cycle.
REQ-026 cmd_valid asserted outside IDLE SHALL be ignored; no queuing.
REQ-027 rsp_data SHALL hold the last response after the handshake until the next DONE.
REQ-028 serial_clk_out SHALL be low in IDLE and DONE. serial_data_out SHALL be 0 in IDLE and DONE.

Reset
REQ-029 On reset: state = IDLE; cmd_ready = 1 in the following cycle; rsp_valid = 0, busy_out = 0, serial_clk_out = 0, serial_data_out = 0, rsp_data = 0; divider and bit counter cleared.
REQ-030 Reset during SHIFT or DONE SHALL abort the transaction. No partial response SHALL be emitted.

Structure
REQ-031 Package mic_serial_pkg SHALL hold the FSM state enum and the parameter defaults.
REQ-032 Sub-module mic_serial_clkgen SHALL generate serial_clk_out and single-cycle rise/fall strobes from CLK_DIV.
REQ-033 The bit counter SHALL be $clog2(WORD_W+1) wide.

Verification (N_CH=4, WORD_W=8, CLK_DIV=2)
REQ-034 Loopback (data_in = data_out per channel), cmd_data {0x00,0xFF,0x3C,0xA5}, mask 0xF -> rsp_data {0x00,0xFF,0x3C,0xA5}, rsp_valid high 33 cycles after acceptance.
REQ-035 Mask 0b0101, loopback -> channels 1,3 serial_data_out constant 0 and rsp words 0x00; channels 0,2 echo their input.
REQ-036 rsp_ready held low 10 cycles after rsp_valid -> rsp_valid and rsp_data stable, cmd_ready = 0, busy_out = 1; release -> IDLE next cycle.
REQ-037 Reset asserted after the 3rd rising edge -> next cycle serial_clk_out = 0, busy_out = 0, no rsp_valid; a new command then completes normally.
REQ-038 cmd_valid held high continuously for 3 transactions -> exactly 3 acceptances, each after the previous response handshake, 8 serial clock pulses each, high/low 2 cycles each.
